gpu_sprite_table: RTL and testbench

//  Consumes the 35-bit GPU instruction stream {code[34:31], index[30:23], data[22:0]}.

---
 rtl/gpu_sprite_table_if.sv | 27 ++
 rtl/gpu_sprite_table.sv | 166 ++++++++++++++++
 tb/tb_gpu_sprite_table.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_sprite_table_if.sv
// Instruction/renderer bus of the sprite attribute table.
// The slave side is the table itself; the master side is the instruction source plus renderer.
interface gpu_sprite_table_if #(
    parameter int NUM_SPRITES = 16,
    parameter int COORD_W     = 11
);
    localparam int IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int DATA_W = 36 + 2 * COORD_W;

    logic [34:0]       Instruction;
    logic              FrameStart;
    logic [IDX_W-1:0]  RdIndex;
    logic [DATA_W-1:0] RdData;
    logic              Busy;
    logic              Overflow;
    logic              CmdError;

    modport master (
        output Instruction, FrameStart, RdIndex,
        input  RdData, Busy, Overflow, CmdError
    );

    modport slave (
        input  Instruction, FrameStart, RdIndex,
        output RdData, Busy, Overflow, CmdError
    );
endinterface

// File: rtl/gpu_sprite_table.sv
// Sprite attribute table: instruction FIFO feeding a shadow table, committed to the
// renderer-visible active table on FrameStart.
module gpu_sprite_table #(
    parameter int NUM_SPRITES = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int COORD_W     = 11
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    gpu_sprite_table_if.slave     bus
);
    localparam int IDX_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DATA_W = 36 + 2 * COORD_W;

    typedef struct packed {
        logic               en;
        logic [7:0]         image;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [7:0]         height;
        logic [7:0]         width;
    } sprite_t;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;

    logic [34:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;

    sprite_t           shadow_q [NUM_SPRITES];
    sprite_t           active_q [NUM_SPRITES];
    sprite_t           rd_q;
    logic              ovf_q;
    logic              cmd_err_q, cmd_err_d;

    logic              push, pop, drop, fifo_full;
    logic [3:0]        in_code;
    logic [34:0]       head;
    logic [3:0]        head_code;
    logic [7:0]        head_idx;
    logic              idx_ok;
    logic              sh_we;
    logic [IDX_W-1:0]  sh_addr;
    sprite_t           sh_wdata;
    logic              unused_data_bits;

    assign in_code   = bus.Instruction[34:31];
    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign head      = fifo_q[rd_ptr_q];
    assign head_code = head[34:31];
    assign head_idx  = head[30:23];
    // Nine-bit compare so NUM_SPRITES=256 still accepts every 8-bit index.
    assign idx_ok    = ({1'b0, head_idx} < 9'(NUM_SPRITES));
    assign unused_data_bits = ^head[22:COORD_W];

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push = (in_code != 4'd0) && (!fifo_full || pop);
    assign drop = (in_code != 4'd0) && fifo_full && !pop;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        pop       = 1'b0;
        cmd_err_d = 1'b0;
        sh_we     = 1'b0;
        sh_addr   = '0;
        sh_wdata  = '0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop = 1'b1;
                    if (head_code == 4'd7) begin
                        state_d   = CLEAR;
                        clr_cnt_d = '0;
                    end else if (head_code >= 4'd8 || !idx_ok) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        sh_we    = 1'b1;
                        sh_addr  = head_idx[IDX_W-1:0];
                        sh_wdata = shadow_q[sh_addr];
                        case (head_code)
                            4'd1:    sh_wdata.image  = head[7:0];
                            4'd2:    sh_wdata.x      = head[COORD_W-1:0];
                            4'd3:    sh_wdata.y      = head[COORD_W-1:0];
                            4'd4:    sh_wdata.height = head[7:0];
                            4'd5:    sh_wdata.width  = head[7:0];
                            4'd6:    sh_wdata.en     = head[0];
                            default: sh_we           = 1'b0;
                        endcase
                    end
                end
            end
            CLEAR: begin
                sh_we     = 1'b1;
                sh_addr   = clr_cnt_q;
                sh_wdata  = '0;
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                if (clr_cnt_q == IDX_W'(NUM_SPRITES - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Storage only; occupancy is tracked by count_q, so no reset is needed here.
    always_ff @(posedge Clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= bus.Instruction;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            cmd_err_q <= 1'b0;
            rd_q      <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            count_q   <= count_d;
            cmd_err_q <= cmd_err_d;
            ovf_q     <= ovf_q | drop;
            if (push)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (sh_we)
                shadow_q[sh_addr] <= sh_wdata;
            // Commit takes the pre-edge shadow; a same-edge apply waits for the next frame.
            if (bus.FrameStart) begin
                for (int i = 0; i < NUM_SPRITES; i++)
                    active_q[i] <= shadow_q[i];
            end
            rd_q <= active_q[bus.RdIndex];
        end
    end

    // Fields occupy the low bits of RdData; the bits above them read as zero.
    assign bus.RdData   = DATA_W'(rd_q);
    assign bus.Busy     = (state_q == CLEAR);
    assign bus.Overflow = ovf_q;
    assign bus.CmdError = cmd_err_q;

endmodule

// File: tb/tb_gpu_sprite_table.sv
// Bench for gpu_sprite_table: directed scenarios then random instruction traffic,
// all checked against a queue/array model of the table.
module tb_gpu_sprite_table;
    localparam int NS = 16;
    localparam int FD = 4;

    typedef struct packed {
        logic        en;
        logic [7:0]  img;
        logic [10:0] x;
        logic [10:0] y;
        logic [7:0]  h;
        logic [7:0]  w;
    } spr_t;

    logic gclk = 1'b0;
    logic grst_n;
    always #5 gclk = ~gclk;

    gpu_sprite_table_if #(.NUM_SPRITES(NS), .COORD_W(11)) bus ();

    gpu_sprite_table #(.NUM_SPRITES(NS), .FIFO_DEPTH(FD), .COORD_W(11)) dut (
        .Clk   (gclk),
        .Rst_n (grst_n),
        .bus   (bus)
    );

    int n_tot = 0;
    int n_bad = 0;

    spr_t        m_sh [NS];
    spr_t        m_ac [NS];
    logic [34:0] m_q [$];
    int          m_clr;
    bit          m_ovf, m_err;
    logic [57:0] m_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [34:0] mk(input int code, input int idx, input int data);
        return {4'(code), 8'(idx), 23'(data)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_sh[i] = '0;
            m_ac[i] = '0;
        end
        m_q.delete();
        m_clr = 0;
        m_ovf = 0;
        m_err = 0;
        m_rd  = '0;
    endtask

    // One clock edge of the table, described by its rules rather than its structure.
    task automatic model_step(input logic [34:0] ins, input bit fs, input int ridx);
        spr_t        old_sh [NS];
        logic [34:0] h;
        int          code, idx;
        bit          pop;
        old_sh = m_sh;
        m_rd   = 58'(m_ac[ridx]);
        m_err  = 0;
        pop    = (m_clr == 0) && (m_q.size() > 0);
        if (m_clr > 0) begin
            m_sh[NS - m_clr] = '0;
            m_clr--;
        end
        if (pop) begin
            h    = m_q.pop_front();
            code = int'(h[34:31]);
            idx  = int'(h[30:23]);
            if (code == 7) m_clr = NS;
            else if (code > 7 || idx >= NS) m_err = 1;
            else begin
                case (code)
                    1: m_sh[idx].img = h[7:0];
                    2: m_sh[idx].x   = h[10:0];
                    3: m_sh[idx].y   = h[10:0];
                    4: m_sh[idx].h   = h[7:0];
                    5: m_sh[idx].w   = h[7:0];
                    6: m_sh[idx].en  = h[0];
                    default: ;
                endcase
            end
        end
        if (ins[34:31] != 4'd0) begin
            if (m_q.size() < FD) m_q.push_back(ins);
            else m_ovf = 1;
        end
        if (fs) m_ac = old_sh;
    endtask

    task automatic tick(input logic [34:0] ins, input bit fs, input int ridx);
        bus.Instruction = ins;
        bus.FrameStart  = fs;
        bus.RdIndex     = 4'(ridx);
        model_step(ins, fs, ridx);
        @(posedge gclk);
        #1;
        chk("rddata", 64'(bus.RdData),   64'(m_rd));
        chk("busy",   64'(bus.Busy),     64'(m_clr > 0));
        chk("ovf",    64'(bus.Overflow), 64'(m_ovf));
        chk("cmderr", 64'(bus.CmdError), 64'(m_err));
    endtask

    task automatic do_reset();
        grst_n          = 1'b0;
        bus.Instruction = '0;
        bus.FrameStart  = 1'b0;
        bus.RdIndex     = '0;
        @(posedge gclk);
        #1;
        model_reset();
        grst_n = 1'b1;
        chk("rst_rd",   64'(bus.RdData),   64'(m_rd));
        chk("rst_busy", 64'(bus.Busy),     64'(m_clr > 0));
        chk("rst_ovf",  64'(bus.Overflow), 64'(m_ovf));
        chk("rst_err",  64'(bus.CmdError), 64'(m_err));
    endtask

    task automatic nops(input int n, input int ridx);
        for (int i = 0; i < n; i++) tick('0, 1'b0, ridx);
    endtask

    initial begin
        int cnt;
        logic [57:0] exp1;
        model_reset();
        do_reset();

        // Full attribute write of entry 0, visible only after a commit.
        tick(mk(1, 0, 5), 0, 0);
        tick(mk(2, 0, 0), 0, 0);
        tick(mk(3, 0, 0), 0, 0);
        tick(mk(4, 0, 40), 0, 0);
        tick(mk(5, 0, 30), 0, 0);
        tick(mk(6, 0, 1), 0, 0);
        nops(3, 0);
        chk("t1_pre_commit", 64'(bus.RdData), 64'd0);
        tick('0, 1'b1, 0);
        tick('0, 1'b0, 0);
        exp1 = 58'({1'b1, 8'd5, 11'd0, 11'd0, 8'd40, 8'd30});
        chk("t1_entry0", 64'(bus.RdData), 64'(exp1));

        // Commit on the apply edge misses the new value.
        tick(mk(2, 3, 'h7FF), 0, 3);
        tick('0, 1'b1, 3);
        tick('0, 1'b0, 3);
        chk("t2_x_old", 64'(bus.RdData[37:27]), 64'd0);
        tick('0, 1'b1, 3);
        tick('0, 1'b0, 3);
        chk("t2_x_new", 64'(bus.RdData[37:27]), 64'd2047);

        // Clear with back-to-back writes piling up behind it.
        tick(mk(7, 0, 0), 0, 0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick(mk(2, i, 100 + i), 0, 0);
            cnt += int'(bus.Busy);
        end
        for (int i = 0; i < 20; i++) begin
            tick('0, 1'b0, 0);
            cnt += int'(bus.Busy);
        end
        chk("t3_busy_cycles", 64'(cnt), 64'd16);
        chk("t3_overflow", 64'(bus.Overflow), 64'd1);
        tick('0, 1'b1, 0);
        for (int i = 0; i < 7; i++) tick('0, 1'b0, i);
        tick('0, 1'b0, 0);
        tick('0, 1'b0, 0);
        chk("t3_entry0_x", 64'(bus.RdData[37:27]), 64'd100);
        tick('0, 1'b0, 5);
        tick('0, 1'b0, 5);
        chk("t3_entry5_x", 64'(bus.RdData[37:27]), 64'd0);

        // Illegal code and out-of-range index each give a single error pulse.
        cnt = 0;
        tick(mk(9, 0, 'h55), 0, 0);
        cnt += int'(bus.CmdError);
        tick(mk(2, 16, 'h55), 0, 0);
        cnt += int'(bus.CmdError);
        for (int i = 0; i < 5; i++) begin
            tick('0, 1'b0, 0);
            cnt += int'(bus.CmdError);
        end
        chk("t4_err_pulses", 64'(cnt), 64'd2);

        // Reset in the middle of a clear with instructions still queued.
        do_reset();
        tick(mk(7, 0, 0), 0, 0);
        tick(mk(1, 1, 'h11), 0, 0);
        tick(mk(1, 2, 'h22), 0, 0);
        nops(3, 0);
        do_reset();
        chk("t5_busy", 64'(bus.Busy), 64'd0);
        chk("t5_rd", 64'(bus.RdData), 64'd0);
        tick(mk(1, 2, 'h33), 0, 2);
        nops(2, 2);
        tick('0, 1'b1, 2);
        nops(2, 1);
        chk("t5_entry1_img", 64'(bus.RdData[45:38]), 64'd0);
        nops(2, 2);
        chk("t5_entry2_img", 64'(bus.RdData[45:38]), 64'h33);

        // Long NOP stream changes nothing.
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick('0, 1'(i % 10 == 0), i % NS);
            cnt += int'(bus.CmdError) + int'(bus.Busy);
        end
        chk("t6_quiet", 64'(cnt), 64'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r, code;
            r = int'($urandom_range(0, 99));
            if (r < 40)      code = 0;
            else if (r < 42) code = 7;
            else if (r < 48) code = int'($urandom_range(8, 15));
            else             code = int'($urandom_range(1, 6));
            if ($urandom_range(0, 399) == 0) do_reset();
            else tick(mk(code, int'($urandom_range(0, 19)), int'($urandom)),
                      1'($urandom_range(0, 7) == 0), int'($urandom_range(0, NS - 1)));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
